// File: rtl/fpmult_control_unit.sv
// ---------------------------------------------------------------------------
// fpmult_control_unit
//
// Sequencer for a byte-serial floating-point multiplier front panel. The user
// presses a single button (enter) to strobe each of the eight operand bytes
// into the datapath. Operand A is loaded first and operand B second, each one
// MSB first. The unit then lets the multiplier settle and latches the
// special-case flags. Further presses step the display through the four
// result bytes, and the press after the last byte starts a new operation.
// If the datapath does not acknowledge a strobe in time, the unit parks in a
// fault state until the next press.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-low reset
//   enter           in   raw push-button level, active high
//   inputdata_ready in   datapath acknowledge of the strobed byte
//   casesspecial    in   [3:0] multiplier special-case flags
//   loaddata        out  one-cycle capture strobe to the datapath
//   op_sel          out  operand being loaded (0 = A, 1 = B)
//   byte_sel        out  [1:0] byte being loaded (3 = MSB)
//   disp_sel        out  [1:0] result byte shown on the displays
//   result_valid    out  result is stable and displayed
//   special         out  OR of casesspecial captured at compute time
//   fault           out  acknowledge timeout occurred
// ---------------------------------------------------------------------------
module fpmult_control_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       inputdata_ready,
  input  logic [3:0] casesspecial,
  output logic       loaddata,
  output logic       op_sel,
  output logic [1:0] byte_sel,
  output logic [1:0] disp_sel,
  output logic       result_valid,
  output logic       special,
  output logic       fault
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD,
    ACK,
    CALC,
    SHOW,
    FAULT
  } state_t;

  state_t          state;
  logic [DB_W-1:0] db_cnt;   // high cycles of enter seen so far
  logic            db_hold;  // press already issued for this high level
  logic [TO_W-1:0] ack_cnt;  // ACK cycles spent without an acknowledge
  logic            press;

  // A press fires on the Nth consecutive high cycle, at most once per level.
  assign press = enter && !db_hold && (db_cnt == DB_LAST);

  // ---------------------------------------------------------------------
  // Button debounce / one-shot
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff sees the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_cnt  <= '0;
      // A button still held through reset must be released before it can
      // count as a new press.
      db_hold <= enter;
    end else if (!enter) begin
      db_cnt  <= '0;
      db_hold <= 1'b0;
    end else if (press) begin
      db_cnt  <= '0;
      db_hold <= 1'b1;
    end else if (!db_hold) begin
      db_cnt  <= db_cnt + DB_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer; every output is a register written here.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LOAD;
      loaddata     <= 1'b0;
      op_sel       <= 1'b0;
      byte_sel     <= 2'd3;
      disp_sel     <= 2'd3;
      result_valid <= 1'b0;
      special      <= 1'b0;
      fault        <= 1'b0;
      ack_cnt      <= '0;
    end else begin
      // NOTE: the strobe defaults low every cycle and is raised only on the
      // LOAD->ACK transition, which makes it a single-cycle pulse by design.
      loaddata <= 1'b0;

      case (state)
        LOAD: begin
          if (press) begin
            loaddata <= 1'b1;
            ack_cnt  <= '0;
            state    <= ACK;
          end
        end

        ACK: begin
          // loaddata is still high during the strobe cycle; an acknowledge
          // seen then cannot belong to this byte and is ignored. Presses are
          // dropped here; the acknowledge always wins.
          if (!loaddata && inputdata_ready) begin
            if (byte_sel != 2'd0) begin
              byte_sel <= byte_sel - 2'd1;
              state    <= LOAD;
            end else if (!op_sel) begin
              op_sel   <= 1'b1;
              byte_sel <= 2'd3;
              state    <= LOAD;
            end else begin
              state    <= CALC;
            end
          end else if (ack_cnt == TO_LAST) begin
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            ack_cnt <= ack_cnt + TO_W'(1);
          end
        end

        // One settle cycle for the multiplier, then capture the flags.
        CALC: begin
          special      <= |casesspecial;
          result_valid <= 1'b1;
          disp_sel     <= 2'd3;
          state        <= SHOW;
        end

        SHOW: begin
          if (press) begin
            if (disp_sel != 2'd0) begin
              disp_sel <= disp_sel - 2'd1;
            end else begin
              result_valid <= 1'b0;
              special      <= 1'b0;
              op_sel       <= 1'b0;
              byte_sel     <= 2'd3;
              disp_sel     <= 2'd3;
              state        <= LOAD;
            end
          end
        end

        FAULT: begin
          if (press) begin
            fault    <= 1'b0;
            op_sel   <= 1'b0;
            byte_sel <= 2'd3;
            state    <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_control_unit.sv
// ---------------------------------------------------------------------------
// tb_fpmult_control_unit
//
// Scoreboarded bench. Stimulus tasks advance a transaction-level model
// (bytes accepted, display presses, fault flag) and push the output vector
// expected after each visible change. A monitor compares every change of the
// DUT output vector against the next queued entry. Cycle-exact properties
// such as timeout length, compute latency and reset values are checked
// inline.
// ---------------------------------------------------------------------------
module tb_fpmult_control_unit;

  localparam int DEB = 4;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       inputdata_ready = 1'b0;
  logic [3:0] casesspecial = 4'd0;
  logic       loaddata, op_sel, result_valid, special, fault;
  logic [1:0] byte_sel, disp_sel;

  fpmult_control_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .ACK_TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enter          (enter),
    .inputdata_ready(inputdata_ready),
    .casesspecial   (casesspecial),
    .loaddata       (loaddata),
    .op_sel         (op_sel),
    .byte_sel       (byte_sel),
    .disp_sel       (disp_sel),
    .result_valid   (result_valid),
    .special        (special),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Output vector: {loaddata, op_sel, byte_sel, disp_sel, result_valid, special, fault}
  logic [8:0] sb[$];
  logic [8:0] prev;
  bit         mon_en = 1'b0;

  // Transaction-level model
  int m_k;        // operand bytes accepted in this operation (0..8)
  int m_shows;    // display presses since the result appeared
  bit m_show;     // result is on display
  bit m_special;  // captured special flag
  bit m_fault;

  localparam logic [8:0] RESET_VEC = {1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0};

  function automatic logic [8:0] model_vec(input bit ld);
    logic       op;
    logic [1:0] bs, ds;
    op = (m_k >= 4);
    bs = (m_k >= 8) ? 2'd0 : 2'(3 - (m_k % 4));
    ds = m_show ? 2'(3 - m_shows) : 2'd3;
    return {ld, op, bs, ds, m_show, m_show & m_special, m_fault};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {loaddata, op_sel, byte_sel, disp_sel, result_valid, special, fault};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_k = 0; m_shows = 0; m_show = 0; m_special = 0; m_fault = 0;
  endtask

  // ------------------------------------------------------------------ monitor
  initial begin
    logic [8:0] cur, exp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = dut_vec();
        if (cur !== prev) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_change: got %b expected no change from %b", cur, prev);
          end else begin
            exp = sb.pop_front();
            if (cur !== exp) begin
              n_errors++;
              $display("FAIL output_sequence: got %b expected %b", cur, exp);
            end
          end
          prev = cur;
        end
      end
    end
  end

  // Apply a one-cycle reset and verify every output at the following cycle.
  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b0;
    tick();
    reset  = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    check("reset_loaddata", loaddata, 0);
    check("reset_op_sel", op_sel, 0);
    check("reset_byte_sel", byte_sel, 3);
    check("reset_disp_sel", disp_sel, 3);
    check("reset_result_valid", result_valid, 0);
    check("reset_special", special, 0);
    check("reset_fault", fault, 0);
    prev   = RESET_VEC;
    mon_en = 1'b1;
    tick();
  endtask

  // Load one operand byte. Optionally raise ready during the strobe cycle
  // (must be ignored) or let a full press coincide with the acknowledge.
  task automatic load_byte(input bit ready_in_strobe, input bit press_with_ready);
    int d;
    d = $urandom_range(1, 4);
    sb.push_back(model_vec(1'b1));
    sb.push_back(model_vec(1'b0));
    m_k++;
    if (m_k == 8) begin
      m_show = 1'b1; m_shows = 0; m_special = |casesspecial;
    end
    sb.push_back(model_vec(1'b0));

    enter = 1'b1;
    repeat (DEB) tick();
    enter = 1'b0;
    inputdata_ready = ready_in_strobe;   // strobe cycle
    tick();
    inputdata_ready = 1'b0;
    if (press_with_ready) begin
      enter = 1'b1;
      repeat (DEB - 1) tick();
      inputdata_ready = 1'b1;            // press fires in this same cycle
      tick();
      enter = 1'b0;
      inputdata_ready = 1'b0;
    end else begin
      repeat (d - 1) tick();
      inputdata_ready = 1'b1;
      tick();
      inputdata_ready = 1'b0;
    end
    if (m_k == 8) begin
      @(negedge clk);
      check("calc_latency_1", result_valid, 0);
      tick();
      @(negedge clk);
      check("calc_latency_2", result_valid, 1);
    end
    tick();
  endtask

  task automatic show_press();
    if (m_shows < 3) begin
      m_shows++;
    end else begin
      m_show = 1'b0; m_shows = 0; m_k = 0;
    end
    sb.push_back(model_vec(1'b0));
    enter = 1'b1;
    repeat (DEB) tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic full_operation(input logic [3:0] cs);
    casesspecial = cs;
    while (m_k < 8) load_byte(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    check("show_result_valid", result_valid, 1);
    check("show_special", special, |cs);
    check("show_disp_sel", disp_sel, 3);
    repeat (4) show_press();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    prev = RESET_VEC;
    repeat (2) tick();
    do_reset();

    // Single press, acknowledge two cycles after the strobe.
    sb.push_back(model_vec(1'b1));
    sb.push_back(model_vec(1'b0));
    m_k++;
    sb.push_back(model_vec(1'b0));
    enter = 1'b1;
    repeat (DEB) tick();
    enter = 1'b0;
    repeat (2) tick();
    inputdata_ready = 1'b1;
    tick();
    inputdata_ready = 1'b0;
    tick();
    check("first_ack_byte_sel", byte_sel, 2);

    // Short press ignored, long press gives one strobe.
    sb.push_back(model_vec(1'b1));
    sb.push_back(model_vec(1'b0));
    m_k++;
    sb.push_back(model_vec(1'b0));
    enter = 1'b1;
    repeat (DEB - 1) tick();
    enter = 1'b0;
    tick();
    enter = 1'b1;
    for (int c = 0; c < 20; c++) begin
      inputdata_ready = (c == DEB + 2);
      tick();
    end
    enter = 1'b0;
    inputdata_ready = 1'b0;
    tick();

    // Finish the operation with a flag set, then two more operations.
    full_operation(4'b0010);
    full_operation(4'b0000);
    full_operation(4'($urandom_range(0, 15)));

    // Acknowledge timeout.
    load_byte(1'b0, 1'b0);
    load_byte(1'b0, 1'b0);
    sb.push_back(model_vec(1'b1));
    sb.push_back(model_vec(1'b0));
    m_fault = 1'b1;
    sb.push_back(model_vec(1'b0));
    enter = 1'b1;
    repeat (DEB) tick();
    enter = 1'b0;
    for (int i = 0; i <= TMO; i++) begin
      @(negedge clk);
      check("fault_timing", fault, (i == TMO) ? 1 : 0);
      tick();
    end
    m_fault = 1'b0;
    m_k = 0;
    sb.push_back(model_vec(1'b0));
    enter = 1'b1;
    repeat (DEB) tick();
    enter = 1'b0;
    tick();
    @(negedge clk);
    check("fault_clear", fault, 0);
    check("fault_op_sel", op_sel, 0);
    check("fault_byte_sel", byte_sel, 3);
    tick();

    // Reset in the middle of ACK for operand B byte 2.
    repeat (5) load_byte(1'b0, 1'b0);
    sb.push_back(model_vec(1'b1));
    sb.push_back(model_vec(1'b0));
    enter = 1'b1;
    repeat (DEB) tick();
    enter = 1'b0;
    tick();
    do_reset();

    // Reset mid-debounce with the button still held: no press until release.
    enter = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    enter = 1'b0;
    tick();
    check("held_through_reset_byte_sel", byte_sel, 3);
    load_byte(1'b0, 1'b0);

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
